// File: rtl/mul4_pkg.sv
// Shared types for the 4x4 multiplier arbiter: FSM state encoding,
// operand/product widths and the multiplier itself.
package mul4_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef logic [OPW-1:0]   operand_t;
  typedef logic [PRODW-1:0] product_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // The one 4x4 unsigned multiplier; operands are widened first so the
  // full 8-bit product is kept.
  function automatic product_t mul4(input operand_t a, input operand_t b);
    return product_t'(a) * product_t'(b);
  endfunction

endpackage

// File: rtl/mul4_rr_arbiter_rr_grant.sv
// Round-robin grant search: picks the first set req bit at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mul4_rr_arbiter.sv
// Round-robin front end sharing one 4x4 multiplier among NREQ requesters.
// One operation in flight, registered result on a valid/ready channel.
// Optional transfer/stall counters are built when MUL4_ARB_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | no valid response held
//   HOLD  | resp_valid=1, waiting for the consumer
module mul4_rr_arbiter
  import mul4_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_result,
  output logic [IDW-1:0]    resp_id
`ifdef MUL4_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall
`endif
);

  state_e          state_q, state_d;
  product_t        result_q, result_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            free;
  logic            xfer;
  operand_t        a_sel, b_sel;

  rr_grant #(.N(NREQ), .IW(IDW)) u_rr_grant (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Slot is free when empty or being drained this cycle; reset masks grants.
  always_comb begin
    free      = (state_q == IDLE) || (resp_ready && (state_q == HOLD));
    req_ready = (free && rst_n) ? gnt : '0;
    xfer      = |req_ready;
    a_sel     = req_a[OPW*int'(gnt_idx) +: OPW];
    b_sel     = req_b[OPW*int'(gnt_idx) +: OPW];
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  // Next state: a transfer loads a new product (also back-to-back from HOLD);
  // a drain without a new grant returns to IDLE keeping result/id.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    if (xfer) begin
      state_d  = HOLD;
      result_d = mul4(a_sel, b_sel);
      id_d     = gnt_idx;
      ptr_d    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
    end else if ((state_q == HOLD) && resp_ready) begin
      state_d = IDLE;
    end
  end

  // Response channel outputs.
  always_comb begin
    resp_valid  = (state_q == HOLD);
    resp_result = result_q;
    resp_id     = id_q;
  end

`ifdef MUL4_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating counters for transfers and backpressured cycles.
  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (xfer && (stat_ops_q != 16'hFFFF))
      stat_ops_d = stat_ops_q + 16'd1;
    if ((state_q == HOLD) && !resp_ready && (stat_stall_q != 16'hFFFF))
      stat_stall_d = stat_stall_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mul4_rr_arbiter.sv
// Directed bench for mul4_rr_arbiter (NREQ=4): reset, fairness, single op,
// backpressure, wrap-around and mid-operation reset.
module tb_mul4_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [7:0]        resp_result;
  logic [IDW-1:0]    resp_id;
`ifdef MUL4_ARB_STATS_EN
  logic [15:0]       stat_ops;
  logic [15:0]       stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  mul4_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
`ifdef MUL4_ARB_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  initial begin
    int fair_id [6];
    fair_id = '{0, 1, 2, 3, 0, 1};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    req_a      = 16'h4321;
    req_b      = 16'h6543;

    // Reset held 3 cycles with everyone requesting.
    repeat (3) begin
      step();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_result", 32'(resp_result), 32'd0);
    end

    // Fairness: a_i=i+1, b_i=i+3 -> products 3,8,15,24.
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'(i + 3));
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_req_ready", 32'(req_ready), 32'(1 << fair_id[k]));
      step();
      chk("fair_valid", 32'(resp_valid), 32'd1);
      chk("fair_id", 32'(resp_id), 32'(fair_id[k]));
      chk("fair_result", 32'(resp_result), 32'((fair_id[k] + 1) * (fair_id[k] + 3)));
    end
    req_valid = 4'h0;
    step();
    chk("drain_valid", 32'(resp_valid), 32'd0);
    chk("drain_keep_id", 32'(resp_id), 32'd1);

    // Single op on requester 2: 15*15.
    set_op(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'h0;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_result", 32'(resp_result), 32'd225);
    chk("single_id", 32'(resp_id), 32'd2);
    step();

    // Backpressure: 7*9 held while requester 2 waits (2*5).
    set_op(3, 4'd7, 4'd9);
    req_valid = 4'b1000;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'b1000);
    step();
    resp_ready = 1'b0;
    set_op(2, 4'd2, 4'd5);
    req_valid = 4'b0100;
    repeat (5) begin
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      step();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_result", 32'(resp_result), 32'd63);
      chk("bp_id", 32'(resp_id), 32'd3);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    step();
    chk("bp_next_result", 32'(resp_result), 32'd10);
    chk("bp_next_id", 32'(resp_id), 32'd2);

    // Wrap: pointer at 3, requesters 3 (0*11) and 0 (1*13) active.
    set_op(3, 4'd0, 4'd11);
    set_op(0, 4'd1, 4'd13);
    req_valid = 4'b1001;
    #1;
    chk("wrap_g3_ready", 32'(req_ready), 32'b1000);
    step();
    chk("wrap_g3_id", 32'(resp_id), 32'd3);
    chk("wrap_g3_result", 32'(resp_result), 32'd0);
    #1;
    chk("wrap_g0_ready", 32'(req_ready), 32'b0001);
    step();
    chk("wrap_g0_id", 32'(resp_id), 32'd0);
    chk("wrap_g0_result", 32'(resp_result), 32'd13);
    #1;
    chk("wrap_g3b_ready", 32'(req_ready), 32'b1000);
    step();
    chk("wrap_g3b_id", 32'(resp_id), 32'd3);
    req_valid = 4'h0;
    step();

    // Mid-op reset: transfer from requester 2 (pointer -> 3), then reset.
    set_op(2, 4'd4, 4'd4);
    set_op(1, 4'd6, 4'd7);
    req_valid = 4'b0100;
    step();
    chk("mid_xfer_result", 32'(resp_result), 32'd16);
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_result", 32'(resp_result), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_g1_ready", 32'(req_ready), 32'b0010);
    step();
    chk("mid_g1_id", 32'(resp_id), 32'd1);
    chk("mid_g1_result", 32'(resp_result), 32'd42);
    #1;
    chk("mid_g2_ready", 32'(req_ready), 32'b0100);
    step();
    chk("mid_g2_id", 32'(resp_id), 32'd2);
    chk("mid_g2_result", 32'(resp_result), 32'd16);
`ifdef MUL4_ARB_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'd2);
    chk("stat_stall", 32'(stat_stall), 32'd0);
`endif
    req_valid = 4'h0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
